temp_sense_monitor: RTL and testbench

TEMP_SENSE_MONITOR -- requirements
Module: temp_sense_monitor

---
 rtl/temp_sense_pkg.sv | 19 +
 rtl/temp_sense_monitor_if.sv | 20 ++
 rtl/temp_c_to_f.sv | 14 +
 rtl/temp_sense_monitor.sv | 201 ++++++++++++++++++++
 tb/tb_temp_sense_monitor.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/temp_sense_pkg.sv
// Shared types and constants for the on-die temperature sensor monitor.
package temp_sense_pkg;

   typedef enum logic [1:0] {
      ST_CLEAR   = 2'd0,
      ST_CONVERT = 2'd1,
      ST_CAPTURE = 2'd2
   } tsm_state_e;

   localparam logic [7:0] BAD_CODE = 8'hFF;

   localparam int DEF_DIV_LOG2   = 11;
   localparam int DEF_SLOT_TICKS = 256;
   localparam int DEF_AVG_LOG2   = 2;
   localparam int DEF_RAW_OFFSET = 133;
   localparam int DEF_ALARM_HI   = 85;
   localparam int DEF_ALARM_LO   = 75;

endpackage

// File: rtl/temp_sense_monitor_if.sv
// ADC-side signal bundle: the monitor (master) drives clock/enable/clear, the ADC answers.
interface temp_sense_monitor_if;

   logic [7:0] tsd_out;
   logic       tsd_done;
   logic       tsd_clk;
   logic       tsd_ce;
   logic       tsd_clr;

   modport master (
      output tsd_clk, tsd_ce, tsd_clr,
      input  tsd_out, tsd_done
   );

   modport slave (
      input  tsd_clk, tsd_ce, tsd_clr,
      output tsd_out, tsd_done
   );

endinterface

// File: rtl/temp_c_to_f.sv
// Celsius to Fahrenheit approximation: F = 2C - C/4 + C/16 + 32 (about 1.8125*C + 32).
module temp_c_to_f (
   input  logic [7:0] temp_c,
   output logic [9:0] temp_f
);

   logic signed [9:0] c_ext_s;
   logic signed [9:0] f_s;

   assign c_ext_s = {{2{temp_c[7]}}, temp_c};
   assign f_s     = (c_ext_s <<< 1) - (c_ext_s >>> 2) + (c_ext_s >>> 4) + 10'sd32;
   assign temp_f  = f_s;

endmodule

// File: rtl/temp_sense_monitor.sv
// Drives the sensor ADC through a fixed slot schedule, averages good samples and
// reports Celsius/Fahrenheit, alarm with hysteresis, min/max and a bad-sample count.
module temp_sense_monitor
   import temp_sense_pkg::*;
#(
   parameter int DIV_LOG2   = DEF_DIV_LOG2,
   parameter int SLOT_TICKS = DEF_SLOT_TICKS,
   parameter int AVG_LOG2   = DEF_AVG_LOG2,
   parameter int RAW_OFFSET = DEF_RAW_OFFSET,
   parameter int ALARM_HI   = DEF_ALARM_HI,
   parameter int ALARM_LO   = DEF_ALARM_LO
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr_minmax,
   temp_sense_monitor_if.master tsd,
   output logic [7:0]           degrees_c,
   output logic [9:0]           degrees_f,
   output logic                 temp_valid,
   output logic                 alarm,
   output logic [7:0]           min_c,
   output logic [7:0]           max_c,
   output logic [7:0]           err_cnt
);

   localparam int SLOT_W = $clog2(SLOT_TICKS);
   localparam int ACC_W  = 8 + AVG_LOG2;
   localparam int CNT_W  = AVG_LOG2 + 1;
   localparam logic [SLOT_W-1:0]  SLOT_LAST = SLOT_W'(SLOT_TICKS - 1);
   localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(1 << AVG_LOG2);
   localparam logic [7:0]         OFFSET_C  = 8'(RAW_OFFSET);
   localparam logic signed [7:0]  HI_C      = 8'(ALARM_HI);
   localparam logic signed [7:0]  LO_C      = 8'(ALARM_LO);

   logic [DIV_LOG2-1:0] div_r;
   logic                tsd_clk_r;
   logic                tick_s;
   logic [SLOT_W-1:0]   slot_r, slot_s;
   tsm_state_e          state_r, state_s;

   logic [7:0]       out_meta_r, out_sync_r;
   logic             done_meta_r, done_sync_r;
   logic             capture_s, good_s, bad_s, full_s;
   logic [ACC_W-1:0] acc_r, sum_s;
   logic [CNT_W-1:0] cnt_r, cnt_inc_s;
   logic [1:0]       pol_r, pol_s;
   logic [7:0]       err_cnt_r, new_c_s;
   logic             tsd_ce_r, tsd_clr_r;

   logic [7:0]        degc_r;
   logic signed [7:0] c_s;
   logic [9:0]        degf_s, degf_r;
   logic              valid_pend_r, temp_valid_r, alarm_r, mm_empty_r;
   logic signed [7:0] min_r, max_r;

   assign tick_s = (div_r == {DIV_LOG2{1'b1}}) && !tsd_clk_r;

   // Slot schedule: the state is a pure function of the slot index, so derive it from the next slot.
   always_comb begin
      slot_s  = slot_r;
      state_s = state_r;
      if (tick_s) begin
         if (slot_r == SLOT_LAST) begin
            slot_s = '0;
         end else begin
            slot_s = slot_r + 1'b1;
         end
         if (slot_s <= SLOT_W'(1)) begin
            state_s = ST_CLEAR;
         end else if (slot_s == SLOT_LAST) begin
            state_s = ST_CAPTURE;
         end else begin
            state_s = ST_CONVERT;
         end
      end else begin
         slot_s  = slot_r;
         state_s = state_r;
      end
   end

   always_comb begin
      capture_s = tick_s && (state_r == ST_CAPTURE);
      good_s    = capture_s && done_sync_r && (out_sync_r != BAD_CODE);
      bad_s     = capture_s && !good_s;
      sum_s     = acc_r + ACC_W'(out_sync_r);
      cnt_inc_s = cnt_r + 1'b1;
      full_s    = good_s && (cnt_inc_s == CNT_FULL);
      new_c_s   = sum_s[AVG_LOG2 +: 8] - OFFSET_C;
      if (bad_s) begin
         pol_s = pol_r + 2'd1;
      end else begin
         pol_s = pol_r;
      end
   end

   // Divider, ADC clock and slot/state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_r     <= '0;
         tsd_clk_r <= 1'b0;
         slot_r    <= '0;
         state_r   <= ST_CLEAR;
      end else begin
         div_r   <= div_r + 1'b1;
         slot_r  <= slot_s;
         state_r <= state_s;
         if (div_r == {DIV_LOG2{1'b1}}) begin
            tsd_clk_r <= !tsd_clk_r;
         end
      end
   end

   // Synchronizers, sample accumulation, error tracking and ADC control pins.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_meta_r   <= 8'd0;
         out_sync_r   <= 8'd0;
         done_meta_r  <= 1'b0;
         done_sync_r  <= 1'b0;
         acc_r        <= '0;
         cnt_r        <= '0;
         pol_r        <= 2'd0;
         err_cnt_r    <= 8'd0;
         degc_r       <= 8'd0;
         valid_pend_r <= 1'b0;
         tsd_ce_r     <= 1'b0;
         tsd_clr_r    <= 1'b1;
      end else begin
         out_meta_r   <= tsd.tsd_out;
         out_sync_r   <= out_meta_r;
         done_meta_r  <= tsd.tsd_done;
         done_sync_r  <= done_meta_r;
         pol_r        <= pol_s;
         valid_pend_r <= full_s;
         tsd_ce_r     <= pol_s[1];
         tsd_clr_r    <= (state_s == ST_CLEAR) ^ pol_s[0];
         if (full_s) begin
            acc_r  <= '0;
            cnt_r  <= '0;
            degc_r <= new_c_s;
         end else if (good_s) begin
            acc_r <= sum_s;
            cnt_r <= cnt_inc_s;
         end
         if (bad_s && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'd1;
         end
      end
   end

   assign c_s = degc_r;

   temp_c_to_f u_c_to_f (
      .temp_c (degc_r),
      .temp_f (degf_s)
   );

   // Result stage: Fahrenheit, valid pulse, alarm hysteresis and min/max all move together.
   always_ff @(posedge clk) begin
      if (rst) begin
         degf_r       <= 10'd0;
         temp_valid_r <= 1'b0;
         alarm_r      <= 1'b0;
         min_r        <= 8'sd0;
         max_r        <= 8'sd0;
         mm_empty_r   <= 1'b1;
      end else begin
         temp_valid_r <= valid_pend_r;
         if (valid_pend_r) begin
            degf_r     <= degf_s;
            mm_empty_r <= 1'b0;
            if (c_s >= HI_C) begin
               alarm_r <= 1'b1;
            end else if (c_s <= LO_C) begin
               alarm_r <= 1'b0;
            end
            if (mm_empty_r || clr_minmax) begin
               min_r <= c_s;
               max_r <= c_s;
            end else begin
               if (c_s < min_r) min_r <= c_s;
               if (c_s > max_r) max_r <= c_s;
            end
         end else if (clr_minmax) begin
            mm_empty_r <= 1'b1;
         end
      end
   end

   assign tsd.tsd_clk = tsd_clk_r;
   assign tsd.tsd_ce  = tsd_ce_r;
   assign tsd.tsd_clr = tsd_clr_r;
   assign degrees_c   = degc_r;
   assign degrees_f   = degf_r;
   assign temp_valid  = temp_valid_r;
   assign alarm       = alarm_r;
   assign min_c       = min_r;
   assign max_c       = max_r;
   assign err_cnt     = err_cnt_r;

endmodule

// File: tb/tb_temp_sense_monitor.sv
// Directed bench: one ADC result per conversion slot, hand-computed expected outputs.
module tb_temp_sense_monitor;

   localparam int SLOT_CLK = 64;  // 2 * 2^2 clk per ADC clock, 8 ADC clocks per slot

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clr_minmax = 1'b0;
   logic [7:0] degrees_c;
   logic [9:0] degrees_f;
   logic       temp_valid;
   logic       alarm;
   logic [7:0] min_c, max_c, err_cnt;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int vcnt = 0;
   int vlast = 0;
   int vprev = 0;
   int exp_v = 0;

   temp_sense_monitor_if tsd ();

   temp_sense_monitor #(
      .DIV_LOG2   (2),
      .SLOT_TICKS (8),
      .AVG_LOG2   (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .clr_minmax (clr_minmax),
      .tsd        (tsd),
      .degrees_c  (degrees_c),
      .degrees_f  (degrees_f),
      .temp_valid (temp_valid),
      .alarm      (alarm),
      .min_c      (min_c),
      .max_c      (max_c),
      .err_cnt    (err_cnt)
   );

   always #5 clk = !clk;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (temp_valid) begin
         vcnt  <= vcnt + 1;
         vprev <= vlast;
         vlast <= cyc;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic feed(input logic [7:0] raw, input logic done, input int n);
      for (int i = 0; i < n; i++) begin
         tsd.tsd_out  = raw;
         tsd.tsd_done = done;
         repeat (SLOT_CLK) @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_temp(input string tag, input logic [7:0] c, input logic [9:0] f, input logic a);
      check_val({tag, "_c"}, 32'(degrees_c), 32'(c));
      check_val({tag, "_f"}, 32'(degrees_f), 32'(f));
      check_val({tag, "_alarm"}, 32'(alarm), 32'(a));
      check_val({tag, "_vcnt"}, 32'(vcnt), 32'(exp_v));
   endtask

   initial begin
      tsd.tsd_out  = 8'd0;
      tsd.tsd_done = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check_val("rst_c", 32'(degrees_c), 32'd0);
      check_val("rst_f", 32'(degrees_f), 32'd0);
      check_val("rst_valid", 32'(temp_valid), 32'd0);
      check_val("rst_tsd_clk", 32'(tsd.tsd_clk), 32'd0);
      check_val("rst_tsd_clr", 32'(tsd.tsd_clr), 32'd1);
      check_val("rst_tsd_ce", 32'(tsd.tsd_ce), 32'd0);
      check_val("rst_err", 32'(err_cnt), 32'd0);
      rst = 1'b0;

      feed(8'd158, 1'b1, 4); exp_v++;
      expect_temp("t25", 8'd25, 10'd77, 1'b0);
      check_val("t25_min", 32'(min_c), 32'd25);
      check_val("t25_max", 32'(max_c), 32'd25);
      feed(8'd158, 1'b1, 4); exp_v++;
      expect_temp("t25b", 8'd25, 10'd77, 1'b0);
      check_val("valid_spacing", 32'(vlast - vprev), 32'd256);

      feed(8'd213, 1'b1, 1); feed(8'd214, 1'b1, 2); feed(8'd215, 1'b1, 1); exp_v++;
      expect_temp("t81", 8'd81, 10'd179, 1'b0);
      feed(8'd218, 1'b1, 4); exp_v++;
      expect_temp("t85", 8'd85, 10'd186, 1'b1);
      feed(8'd209, 1'b1, 4); exp_v++;
      expect_temp("t76", 8'd76, 10'd169, 1'b1);
      feed(8'd208, 1'b1, 4); exp_v++;
      expect_temp("t75", 8'd75, 10'd168, 1'b0);
      check_val("t75_min", 32'(min_c), 32'd25);
      check_val("t75_max", 32'(max_c), 32'd85);

      feed(8'd158, 1'b0, 3);
      check_val("bad3_err", 32'(err_cnt), 32'd3);
      check_val("bad3_ce", 32'(tsd.tsd_ce), 32'd1);
      check_val("bad3_vcnt", 32'(vcnt), 32'(exp_v));
      check_val("bad3_c", 32'(degrees_c), 32'd75);
      feed(8'hFF, 1'b1, 1);
      check_val("badff_err", 32'(err_cnt), 32'd4);
      check_val("badff_ce", 32'(tsd.tsd_ce), 32'd0);
      feed(8'd158, 1'b1, 4); exp_v++;
      expect_temp("after_bad", 8'd25, 10'd77, 1'b0);

      feed(8'd123, 1'b1, 4); exp_v++;
      expect_temp("tneg", 8'hF6, 10'h00E, 1'b0);
      check_val("tneg_min", 32'(min_c), 32'hF6);
      check_val("tneg_max", 32'(max_c), 32'd85);

      clr_minmax = 1'b1;
      @(posedge clk);
      #1;
      clr_minmax = 1'b0;
      feed(8'd158, 1'b1, 4); exp_v++;
      check_val("clr_min", 32'(min_c), 32'd25);
      check_val("clr_max", 32'(max_c), 32'd25);

      feed(8'd218, 1'b1, 4); exp_v++;
      expect_temp("pre_rst", 8'd85, 10'd186, 1'b1);

      feed(8'd200, 1'b1, 2);
      rst = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check_val("mid_rst_c", 32'(degrees_c), 32'd0);
      check_val("mid_rst_f", 32'(degrees_f), 32'd0);
      check_val("mid_rst_alarm", 32'(alarm), 32'd0);
      check_val("mid_rst_min", 32'(min_c), 32'd0);
      check_val("mid_rst_max", 32'(max_c), 32'd0);
      check_val("mid_rst_err", 32'(err_cnt), 32'd0);
      check_val("mid_rst_vcnt", 32'(vcnt), 32'(exp_v));
      rst = 1'b0;
      feed(8'd170, 1'b1, 4); exp_v++;
      expect_temp("post_rst", 8'd37, 10'd99, 1'b0);
      check_val("post_rst_min", 32'(min_c), 32'd37);
      check_val("post_rst_max", 32'(max_c), 32'd37);

      feed(8'd158, 1'b0, 300);
      check_val("sat_err", 32'(err_cnt), 32'd255);
      check_val("sat_c", 32'(degrees_c), 32'd37);
      check_val("sat_vcnt", 32'(vcnt), 32'(exp_v));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
